// File: rtl/byte_word_packer_pkg.sv
// Shared debug-path constants and lane helpers.
// Used by the byte/word packers and the UART debug unit.
package byte_word_packer_pkg;

    localparam int N_LANES              = 4;
    localparam int LANE_W               = 2;
    localparam int DEBUG_TIMEOUT_CYCLES = 1000;

    typedef logic [LANE_W-1:0] lane_t;

    // Bit offset of a lane; lane 0 is the MSB lane when msb_first is set.
    function automatic int lane_lsb(input int lane, input bit msb_first,
                                    input int nb_byte);
        return msb_first ? (N_LANES - 1 - lane) * nb_byte : lane * nb_byte;
    endfunction

endpackage

// File: rtl/byte_word_packer_word_out_reg.sv
// One-entry valid/ready holding register.
// A load may coincide with a drain, giving back-to-back words with no bubble.
module word_out_reg #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/byte_word_packer.sv
// Byte stream to 32-bit word assembler for the debug loader path.
// Partial words are dropped after an idle timeout.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int NB_BYTE        = 8,
    parameter int NB_WORD        = 32,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = DEBUG_TIMEOUT_CYCLES
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_byte_valid,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic               o_byte_ready,
    output logic               o_word_valid,
    output logic [NB_WORD-1:0] o_word,
    input  logic               i_word_ready,
    output logic [1:0]         o_count,
    output logic               o_timeout
);

    lane_t                  count_q, count_d;
    logic [NB_WORD-1:0]     asm_q, asm_d, asm_ins;
    logic [NB_TIMEOUT-1:0]  idle_q, idle_d;
    logic                   timeout_q, timeout_d;
    logic                   accept, complete, fire, word_valid;

    localparam lane_t LAST = lane_t'(N_LANES - 1);

    assign o_byte_ready = !i_clear &&
        !(count_q == LAST && word_valid && !i_word_ready);
    assign accept   = i_byte_valid && o_byte_ready;
    assign complete = accept && count_q == LAST;
    assign fire     = (TIMEOUT_CYCLES != 0) && count_q != '0 &&
        !accept && !i_clear && idle_q == NB_TIMEOUT'(TIMEOUT_CYCLES);

    always_comb begin
        asm_ins = asm_q;
        for (int k = 0; k < N_LANES; k++) begin
            if (count_q == lane_t'(k))
                asm_ins[lane_lsb(k, MSB_FIRST, NB_BYTE) +: NB_BYTE] = i_byte;
        end
    end

    always_comb begin
        count_d   = count_q;
        asm_d     = asm_q;
        idle_d    = idle_q;
        timeout_d = 1'b0;
        if (i_clear) begin
            count_d = '0;
            asm_d   = '0;
            idle_d  = '0;
        end else if (accept) begin
            count_d = count_q + lane_t'(1);
            asm_d   = complete ? '0 : asm_ins;
            idle_d  = '0;
        end else if (fire) begin
            count_d   = '0;
            asm_d     = '0;
            idle_d    = '0;
            timeout_d = 1'b1;
        end else if (count_q != '0 && TIMEOUT_CYCLES != 0) begin
            idle_d = idle_q + NB_TIMEOUT'(1);
        end else begin
            idle_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q   <= '0;
            asm_q     <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            asm_q     <= asm_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    word_out_reg #(
        .W(NB_WORD)
    ) u_out (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_clear),
        .i_load  (complete),
        .i_data  (asm_ins),
        .i_ready (i_word_ready),
        .o_valid (word_valid),
        .o_data  (o_word)
    );

    assign o_word_valid = word_valid;
    assign o_count      = count_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench: MSB-first and LSB-first packers driven in lockstep.
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        bvalid;
    logic [7:0]  bdata;
    logic        wready;

    logic        a_brdy, a_wvalid, a_tmo;
    logic [31:0] a_word;
    logic [1:0]  a_cnt;
    logic        b_brdy, b_wvalid, b_tmo;
    logic [31:0] b_word;
    logic [1:0]  b_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    byte_word_packer #(
        .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(5)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
        .i_byte_valid(bvalid), .i_byte(bdata), .o_byte_ready(a_brdy),
        .o_word_valid(a_wvalid), .o_word(a_word),
        .i_word_ready(wready), .o_count(a_cnt), .o_timeout(a_tmo)
    );

    byte_word_packer #(
        .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(5)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
        .i_byte_valid(bvalid), .i_byte(bdata), .o_byte_ready(b_brdy),
        .o_word_valid(b_wvalid), .o_word(b_word),
        .i_word_ready(wready), .o_count(b_cnt), .o_timeout(b_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bvalid = 1'b1;
        bdata  = b;
        step();
    endtask

    initial begin
        rst_n  = 1'b0;
        clear  = 1'b0;
        bvalid = 1'b0;
        bdata  = 8'h00;
        wready = 1'b1;
        #12;
        chk("rst_valid", 32'(a_wvalid), 32'd0);
        chk("rst_word", a_word, 32'd0);
        chk("rst_count", 32'(a_cnt), 32'd0);
        chk("rst_timeout", 32'(a_tmo), 32'd0);
        rst_n = 1'b1;
        step();

        // MSB-first and LSB-first assembly
        send(8'hDE); chk("seq_cnt1", 32'(a_cnt), 32'd1);
        send(8'hAD); chk("seq_cnt2", 32'(a_cnt), 32'd2);
        send(8'hBE); chk("seq_cnt3", 32'(a_cnt), 32'd3);
        chk("seq_valid_early", 32'(a_wvalid), 32'd0);
        send(8'hEF); chk("seq_cnt0", 32'(a_cnt), 32'd0);
        chk("msb_valid", 32'(a_wvalid), 32'd1);
        chk("msb_word", a_word, 32'hDEADBEEF);
        chk("lsb_word", b_word, 32'hEFBEADDE);
        chk("lsb_cnt", 32'(b_cnt), 32'd0);
        bvalid = 1'b0;
        step();
        chk("msb_valid_drop", 32'(a_wvalid), 32'd0);
        chk("word_held", a_word, 32'hDEADBEEF);

        // Backpressure
        wready = 1'b0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("bp_word1", a_word, 32'h11223344);
        chk("bp_valid1", 32'(a_wvalid), 32'd1);
        send(8'h55); send(8'h66); send(8'h77);
        chk("bp_cnt3", 32'(a_cnt), 32'd3);
        bdata = 8'h88;
        #1;
        chk("bp_stall_rdy", 32'(a_brdy), 32'd0);
        chk("bp_stall_rdy_b", 32'(b_brdy), 32'd0);
        step();
        chk("bp_stall_cnt", 32'(a_cnt), 32'd3);
        chk("bp_stall_word", a_word, 32'h11223344);
        wready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(a_brdy), 32'd1);
        step();
        chk("bp_word2", a_word, 32'h55667788);
        chk("bp_valid2", 32'(a_wvalid), 32'd1);
        chk("bp_cnt0", 32'(a_cnt), 32'd0);
        bvalid = 1'b0;
        step();
        chk("bp_drain", 32'(a_wvalid), 32'd0);

        // Idle timeout drops a partial word
        send(8'hAA);
        bvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("tmo_wait_pulse", 32'(a_tmo), 32'd0);
            chk("tmo_wait_cnt", 32'(a_cnt), 32'd1);
        end
        step();
        chk("tmo_pulse", 32'(a_tmo), 32'd1);
        chk("tmo_pulse_b", 32'(b_tmo), 32'd1);
        chk("tmo_cnt", 32'(a_cnt), 32'd0);
        step();
        chk("tmo_one_shot", 32'(a_tmo), 32'd0);

        // Accept at the limit beats the timeout
        send(8'hAA);
        bvalid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        send(8'hBB);
        chk("tmo_race_pulse", 32'(a_tmo), 32'd0);
        chk("tmo_race_cnt", 32'(a_cnt), 32'd2);
        send(8'hCC); send(8'hDD);
        chk("tmo_race_word", a_word, 32'hAABBCCDD);

        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("post_tmo_word", a_word, 32'h01020304);
        chk("post_tmo_valid", 32'(a_wvalid), 32'd1);

        // Clear mid-word with the output register full
        wready = 1'b0;
        send(8'hAA); send(8'hBB);
        chk("clr_pre_cnt", 32'(a_cnt), 32'd2);
        clear = 1'b1;
        bdata = 8'hCC;
        #1;
        chk("clr_rdy", 32'(a_brdy), 32'd0);
        step();
        chk("clr_cnt", 32'(a_cnt), 32'd0);
        chk("clr_valid", 32'(a_wvalid), 32'd0);
        clear  = 1'b0;
        bvalid = 1'b0;
        step();
        chk("clr_cc_rejected", 32'(a_cnt), 32'd0);
        wready = 1'b1;

        // Async reset mid-word
        send(8'h9A); send(8'hBC); send(8'hDE); send(8'hF0);
        send(8'h9A); send(8'hBC);
        bvalid = 1'b0;
        chk("ar_pre_cnt", 32'(a_cnt), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_cnt", 32'(a_cnt), 32'd0);
        chk("ar_valid", 32'(a_wvalid), 32'd0);
        chk("ar_word", a_word, 32'd0);
        chk("ar_tmo", 32'(a_tmo), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        chk("ar_msb_word", a_word, 32'h12345678);
        chk("ar_lsb_word", b_word, 32'h78563412);
        chk("ar_valid_after", 32'(a_wvalid), 32'd1);
        bvalid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
